// File: rtl/gfx256_pkg.sv
// Shared gfx256 types: 256-bit Wishbone command bus structs, responder FSM states.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package gfx256_pkg;

    localparam int GFX256_LINE_BYTES = 32;
    localparam int GFX256_TID_W      = 8;

    typedef struct packed {
        logic                          cyc;
        logic                          stb;
        logic                          we;
        logic [GFX256_LINE_BYTES-1:0]  sel;
        logic [31:0]                   padr;
        logic [8*GFX256_LINE_BYTES-1:0] dat;
        logic [GFX256_TID_W-1:0]       tid;
    } wb_cmd_request256_t;

    typedef struct packed {
        logic                          ack;
        logic                          err;
        logic                          rty;
        logic [8*GFX256_LINE_BYTES-1:0] dat;
        logic [GFX256_TID_W-1:0]       tid;
    } wb_cmd_response256_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        RESP  = 2'd2,
        CLEAR = 2'd3
    } gfx256_wbs_state_e;

    // True when padr falls in the window of 2^(5+depth_log2) bytes starting at base.
    // Only the bits above the window are compared; the low bits select line/byte.
    function automatic logic fnWbsHit(input logic [31:0] padr,
                                      input logic [31:0] base,
                                      input int unsigned depth_log2);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (5 + depth_log2);
        return ((padr ^ base) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/gfx256_bram_be.sv
// Single-port line RAM, 2^DEPTH_LOG2 x 256 bits, 32 byte-write enables, registered read.
// Latency: write lands on the clock edge; read data valid one cycle after addr.
// Backpressure: none; always ready. Contents are not reset.
// Ports: clk; we/be/addr/wdat write side; rdat registered read of addr.
module gfx256_bram_be
    import gfx256_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [GFX256_LINE_BYTES-1:0]    be,
    input  logic [DEPTH_LOG2-1:0]           addr,
    input  logic [8*GFX256_LINE_BYTES-1:0]  wdat,
    output logic [8*GFX256_LINE_BYTES-1:0]  rdat
);

    logic [8*GFX256_LINE_BYTES-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < GFX256_LINE_BYTES; k++) begin
                if (be[k]) begin
                    mem[addr][8*k +: 8] <= wdat[8*k +: 8];
                end
            end
        end
        rdat <= mem[addr];
    end

endmodule

// File: rtl/gfx256_wbs_ram.sv
// Wishbone 256-bit responder onto a local byte-enabled line RAM, plus a zeroing clear engine.
// Latency: write ack 1 cycle after stb sampled, read ack 2 cycles; clear takes 2^DEPTH_LOG2 cycles.
// Backpressure: requests stall (no ack/err) during a clear; response held until master drops stb.
// Ports: clk_i, rst_ni (async, active low); wbs_req/wbs_resp bus; clr_i pulse starts clear; clr_busy_o.
module gfx256_wbs_ram
    import gfx256_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  wb_cmd_request256_t  wbs_req,
    output wb_cmd_response256_t wbs_resp,
    input  logic                clr_i,
    output logic                clr_busy_o
);

    localparam int IDX_HI = 4 + DEPTH_LOG2;

    gfx256_wbs_state_e              state_q, state_d;
    logic [DEPTH_LOG2-1:0]          cnt_q, cnt_d;
    logic                           pend_q, pend_d;
    logic                           busy_q, busy_d;
    logic [GFX256_TID_W-1:0]        tid_q, tid_d;
    wb_cmd_response256_t            resp_q, resp_d;

    logic                           req_act;
    logic                           hit;
    logic [DEPTH_LOG2-1:0]          req_idx;

    logic                           ram_we;
    logic [GFX256_LINE_BYTES-1:0]   ram_be;
    logic [DEPTH_LOG2-1:0]          ram_addr;
    logic [8*GFX256_LINE_BYTES-1:0] ram_wdat;
    logic [8*GFX256_LINE_BYTES-1:0] ram_rdat;

    assign req_act = wbs_req.cyc & wbs_req.stb;
    assign hit     = req_act & fnWbsHit(wbs_req.padr, BASE_ADDR, DEPTH_LOG2);
    assign req_idx = wbs_req.padr[IDX_HI:5];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            tid_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            tid_q   <= tid_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        busy_d   = busy_q;
        tid_d    = tid_q;
        resp_d   = resp_q;
        ram_we   = 1'b0;
        ram_be   = wbs_req.sel;
        ram_addr = req_idx;
        ram_wdat = wbs_req.dat;

        case (state_q)
            IDLE: begin
                // A pending or fresh clear wins; any same-cycle request just waits.
                if (pend_q || clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else if (req_act && !hit) begin
                    resp_d     = '0;
                    resp_d.err = 1'b1;
                    resp_d.tid = wbs_req.tid;
                    state_d    = RESP;
                end else if (hit && wbs_req.we) begin
                    ram_we     = 1'b1;
                    resp_d     = '0;
                    resp_d.ack = 1'b1;
                    resp_d.tid = wbs_req.tid;
                    state_d    = RESP;
                end else if (hit) begin
                    // Index already on the RAM address; data returns next cycle.
                    tid_d   = wbs_req.tid;
                    state_d = RD;
                end
            end

            RD: begin
                // Completes even if the master aborted; RESP then retires it at once.
                resp_d     = '0;
                resp_d.ack = 1'b1;
                resp_d.dat = ram_rdat;
                resp_d.tid = tid_q;
                state_d    = RESP;
                if (clr_i) pend_d = 1'b1;
            end

            RESP: begin
                if (clr_i) pend_d = 1'b1;
                if (!req_act) begin
                    resp_d  = '0;
                    state_d = IDLE;
                end
            end

            CLEAR: begin
                ram_we   = 1'b1;
                ram_be   = '1;
                ram_addr = cnt_q;
                ram_wdat = '0;
                if (&cnt_q) begin
                    busy_d  = 1'b0;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    gfx256_bram_be #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk  (clk_i),
        .we   (ram_we),
        .be   (ram_be),
        .addr (ram_addr),
        .wdat (ram_wdat),
        .rdat (ram_rdat)
    );

    assign wbs_resp   = resp_q;
    assign clr_busy_o = busy_q;

endmodule

// File: tb/tb_gfx256_wbs_ram.sv
// Self-checking bench for gfx256_wbs_ram: directed scenarios plus randomized traffic
// against a byte-array memory model.
// Latency/backpressure expectations are derived from the bus protocol, not the FSM.
module tb_gfx256_wbs_ram;
    import gfx256_pkg::*;

    localparam int          D     = 8;
    localparam int          LINES = 1 << D;
    localparam logic [31:0] BASE  = 32'h0004_0000;
    localparam logic [31:0] SPAN  = 32'(LINES * 32);

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                clr_i = 1'b0;
    logic                busy;
    wb_cmd_request256_t  req;
    wb_cmd_response256_t resp;

    logic [255:0] model [0:LINES-1];
    int n_cmp = 0;
    int n_bad = 0;

    gfx256_wbs_ram #(.DEPTH_LOG2(D), .BASE_ADDR(BASE)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wbs_req    (req),
        .wbs_resp   (resp),
        .clr_i      (clr_i),
        .clr_busy_o (busy)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_write(input int line, input logic [31:0] sel, input logic [255:0] dat);
        logic [255:0] m;
        m = '0;
        for (int k = 0; k < 32; k++) if (sel[k]) m[8*k +: 8] = 8'hFF;
        model[line] = (model[line] & ~m) | (dat & m);
    endtask

    task automatic model_zero();
        for (int i = 0; i < LINES; i++) model[i] = '0;
    endtask

    // One classic cycle. exp_lat < 0 skips the latency check (e.g. stalled by a clear).
    task automatic op(input string tag, input logic we, input logic [31:0] padr,
                      input logic [31:0] sel, input logic [255:0] dat, input logic [7:0] tid,
                      input int exp_lat, input int hold);
        logic [31:0]  off;
        logic         in_rng;
        int           line;
        logic [255:0] exp_dat;
        int           n;
        logic         seen;
        off     = padr - BASE;
        in_rng  = off < SPAN;
        line    = int'(off / 32);
        exp_dat = (in_rng && !we) ? model[line] : '0;

        @(posedge clk_i); #1;
        req.cyc = 1'b1; req.stb = 1'b1; req.we = we;
        req.sel = sel; req.padr = padr; req.dat = dat; req.tid = tid;
        @(negedge clk_i);
        check({tag, "_early"}, resp.ack | resp.err, 1'b0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk_i);
            n++;
            seen = resp.ack | resp.err;
        end
        check({tag, "_seen"}, seen, 1'b1);
        if (exp_lat >= 0) check({tag, "_lat"}, n, exp_lat);
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk_i);
            check({tag, "_ack"}, resp.ack, in_rng);
            check({tag, "_err"}, resp.err, !in_rng);
            check({tag, "_dat"}, resp.dat, exp_dat);
            check({tag, "_tid"}, resp.tid, tid);
        end
        if (in_rng && we) model_write(line, sel, dat);
        req.cyc = 1'b0;
        req.stb = 1'b0;
        @(negedge clk_i);
        check({tag, "_idle"}, {resp.ack, resp.err, resp.tid}, 10'd0);
    endtask

    task automatic pulse_clr();
        @(posedge clk_i); #1 clr_i = 1'b1;
        @(posedge clk_i); #1 clr_i = 1'b0;
    endtask

    // Called at a negedge; counts consecutive negedges with busy high.
    task automatic count_busy(output int c);
        int g;
        c = 0;
        g = 0;
        while (busy === 1'b1 && g < 2000) begin
            c++;
            g++;
            @(negedge clk_i);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] a, b, c;
        int           bc;
        req = '0;

        // Reset state
        #12;
        check("rst_ack", resp.ack, 1'b0);
        check("rst_err", resp.err, 1'b0);
        check("rst_dat", resp.dat, '0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Initial clear gives the RAM known contents
        pulse_clr();
        @(negedge clk_i);
        count_busy(bc);
        check("clr0_cycles", bc, 256);
        model_zero();

        // Full write then read back
        a = rand256();
        op("wrA", 1'b1, BASE + 32'h40, 32'hFFFF_FFFF, a, 8'h51, 1, 0);
        op("rdA", 1'b0, BASE + 32'h40, 32'hFFFF_FFFF, '0, 8'h52, 2, 1);

        // Partial write over line holding A
        op("wrP", 1'b1, BASE + 32'h40, 32'h0000_000F, {224'd0, 32'hDEADBEEF}, 8'h53, 1, 0);
        op("rdP", 1'b0, BASE + 32'h40, 32'hFFFF_FFFF, '0, 8'h54, 2, 0);
        check("partial_lo", model[2][31:0], 32'hDEADBEEF);

        // Out-of-range write leaves RAM untouched
        op("wr_last", 1'b1, BASE + SPAN - 32, 32'hFFFF_FFFF, rand256(), 8'h55, 1, 0);
        op("oor", 1'b1, BASE + SPAN, 32'hFFFF_FFFF, rand256(), 8'h56, 1, 0);
        op("rd0", 1'b0, BASE, 32'hFFFF_FFFF, '0, 8'h57, 2, 0);
        op("rdL", 1'b0, BASE + SPAN - 32, 32'hFFFF_FFFF, '0, 8'h58, 2, 0);

        // Clear with a read arriving shortly after: stalled, then returns zero
        model_zero();
        fork
            begin
                int cc;
                pulse_clr();
                @(negedge clk_i);
                count_busy(cc);
                check("clr1_cycles", cc, 256);
            end
            begin
                repeat (3) @(posedge clk_i);
                op("rd_during_clr", 1'b0, BASE + 32'h40, 32'hFFFF_FFFF, '0, 8'h59, -1, 0);
            end
        join

        // clr_i while reading line 5: old data returned, clear starts right after
        b = rand256();
        op("wr5", 1'b1, BASE + 5*32, 32'hFFFF_FFFF, b, 8'h5A, 1, 0);
        fork
            op("rd5", 1'b0, BASE + 5*32, 32'hFFFF_FFFF, '0, 8'h5B, 2, 0);
            begin
                @(posedge clk_i);
                @(posedge clk_i); #1 clr_i = 1'b1;
                @(posedge clk_i); #1 clr_i = 1'b0;
            end
        join
        check("pend_not_yet", busy, 1'b0);
        @(negedge clk_i);
        check("pend_started", busy, 1'b1);
        fork
            count_busy(bc);
            begin
                repeat (100) @(posedge clk_i);
                #1 clr_i = 1'b1;
                @(posedge clk_i); #1 clr_i = 1'b0;
            end
        join
        check("clr2_cycles", bc, 256);
        model_zero();
        op("rd5_zero", 1'b0, BASE + 5*32, 32'hFFFF_FFFF, '0, 8'h5C, 2, 0);

        // Asynchronous reset while ack is held
        c = rand256();
        @(posedge clk_i); #1;
        req.cyc = 1'b1; req.stb = 1'b1; req.we = 1'b1;
        req.sel = 32'hFFFF_FFFF; req.padr = BASE + 7*32; req.dat = c; req.tid = 8'h60;
        @(negedge clk_i);
        @(negedge clk_i);
        check("pre_rst_ack", resp.ack, 1'b1);
        model_write(7, 32'hFFFF_FFFF, c);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_ack", resp.ack, 1'b0);
        check("async_rst_tid", resp.tid, 8'h00);
        req.cyc = 1'b0;
        req.stb = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        op("post_wr", 1'b1, BASE + 9*32, 32'hFFFF_FFFF, rand256(), 8'h61, 1, 0);
        op("post_rd", 1'b0, BASE + 9*32, 32'hFFFF_FFFF, '0, 8'h62, 2, 0);
        op("post_rd7", 1'b0, BASE + 7*32, 32'hFFFF_FFFF, '0, 8'h63, 2, 0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            logic [31:0] padr, sel;
            logic        we, oor;
            int          r;
            oor = ($urandom_range(0, 9) == 0);
            if (oor) padr = BASE ^ (32'h1 << $urandom_range(13, 31)) ^ 32'($urandom_range(0, 8191));
            else     padr = BASE + 32'($urandom_range(0, LINES - 1) * 32 + $urandom_range(0, 31));
            we = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 3);
            sel = (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFF_FFFF : $urandom;
            op("rnd", we, padr, sel, rand256(), 8'($urandom), (oor || we) ? 1 : 2,
               $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
